uart_id_transmitter: RTL and testbench

Serial transmitter for the voice-ID link. It is the sending end of the framing that UART_Receiver decodes.
- Accepts 8-bit word IDs (0 idle, 5 start, 46 done, 47 next, digit codes) into a small FIFO.
- Serialises each ID as one start-low period, 8 data bits MSB-first, a stop bit and a guard-idle bit.
- Sits on the host/test side; it drives the rx input of Top for loopback and bring-up.

---
 rtl/uart_id_transmitter.sv | 186 ++++++++++++++++++
 tb/tb_uart_id_transmitter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_id_transmitter.sv
// Serial word-ID transmitter: FIFO-buffered IDs sent as start(2 bits low), 8 data bits MSB-first, stop, guard.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_id_transmitter #(
  parameter int BIT_TICKS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          nRESET,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BIT_TICKS) + 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(BIT_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP,
    GUARD
  } state_t;

  // ---------------- ID FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, fifo_empty;

  assign tx_ready   = (count != CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign fifo_empty = (count == '0);
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- frame FSM ----------------
  state_t        state, nstate;
  logic [TW-1:0] tick, ntick;
  logic [2:0]    bit_cnt, nbit;
  logic [7:0]    shift, nshift;
  logic          tx_q, ntx;
  logic          done_q, ndone;
  logic          tick_last, load;
`ifdef UART_TX_PARITY_EN
  logic          par_q, npar;
`endif

  assign tick_last = (tick == TICK_MAX);

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= nstate;
      tick    <= ntick;
      bit_cnt <= nbit;
      shift   <= nshift;
      tx_q    <= ntx;
      done_q  <= ndone;
`ifdef UART_TX_PARITY_EN
      par_q   <= npar;
`endif
    end
  end

  always_comb begin
    nstate = state;
    ntick  = tick_last ? '0 : tick + TW'(1);
    nbit   = bit_cnt;
    nshift = shift;
    ndone  = 1'b0;
    load   = 1'b0;
    pop    = 1'b0;
`ifdef UART_TX_PARITY_EN
    npar   = par_q;
`endif
    unique case (state)
      IDLE: begin
        ntick = '0;
        if (!fifo_empty) load = 1'b1;
      end
      // Two bit periods low: the receiver detects, then confirms, the start.
      START: begin
        if (tick_last) begin
          if (bit_cnt == 3'd1) begin
            nstate = DATA;
            nbit   = '0;
          end else begin
            nbit = bit_cnt + 3'd1;
          end
        end
      end
      DATA: begin
        if (tick_last) begin
          if (bit_cnt == 3'd7) begin
            nbit = '0;
`ifdef UART_TX_PARITY_EN
            nstate = PARITY;
`else
            nstate = STOP;
`endif
          end else begin
            nshift = {shift[6:0], 1'b0};
            nbit   = bit_cnt + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick_last) nstate = STOP;
`endif
      STOP: if (tick_last) nstate = GUARD;
      // Chain straight into the next frame so queued IDs go out contiguously.
      GUARD: begin
        if (tick_last) begin
          ndone = 1'b1;
          if (!fifo_empty) load = 1'b1;
          else             nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase

    if (load) begin
      pop    = 1'b1;
      nshift = mem[rd_ptr];
      nstate = START;
      nbit   = '0;
      ntick  = '0;
`ifdef UART_TX_PARITY_EN
      npar   = ^mem[rd_ptr];
`endif
    end

    // tx is registered from the next state so the line changes on the same edge as the state.
    unique case (nstate)
      START:   ntx = 1'b0;
      DATA:    ntx = nshift[7];
`ifdef UART_TX_PARITY_EN
      PARITY:  ntx = npar;
`endif
      default: ntx = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = (state != IDLE);
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_id_transmitter.sv
// Directed bench for uart_id_transmitter (default build): vector table plus hand-written multi-cycle sequences.
module tb_uart_id_transmitter;

  logic       clk = 1'b0;
  logic       nRESET;
  logic [7:0] tx_data, tx_data4;
  logic       tx_valid, tx_valid4;
  logic       tx_ready, tx, tx_busy, tx_done;
  logic       tx_ready4, tx4, tx_busy4, tx_done4;
  logic [2:0] fifo_count, fifo_count4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_id_transmitter #(.BIT_TICKS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .nRESET(nRESET), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done),
    .fifo_count(fifo_count)
  );

  uart_id_transmitter #(.BIT_TICKS(4), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .nRESET(nRESET), .tx_data(tx_data4), .tx_valid(tx_valid4),
    .tx_ready(tx_ready4), .tx(tx4), .tx_busy(tx_busy4), .tx_done(tx_done4),
    .fifo_count(fifo_count4)
  );

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic       tx;
    logic       busy;
    logic       done;
    logic [2:0] cnt;
    logic       rdy;
  } vec_t;

  vec_t       tbl [15];
  logic [7:0] pv [6];
  logic [7:0] ev [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tx_valid = 0; tx_data = 0; tx_valid4 = 0; tx_data4 = 0;
    nRESET = 0;
    step(); step();
    nRESET = 1;
    step();
  endtask

  // Frame bit i (0..11) of an ID: two start lows, data MSB first, stop and guard highs.
  function automatic logic exp_bit(input logic [7:0] id, input int i);
    if (i < 2)  return 1'b0;
    if (i < 10) return id[9-i];
    return 1'b1;
  endfunction

  // Push pv[0..npush-1] on consecutive clocks; expect nf contiguous frames of ev[].
  task automatic run_seq(input int npush, input int nf, input int mode);
    int peak;
    logic et, eb, ed;
    peak = 0;
    for (int c = 0; c <= 12*nf + 4; c++) begin
      tx_valid = (c < npush);
      tx_data  = (c < npush) ? pv[c] : 8'h00;
      step();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (c >= 1) begin
        et = (c <= 12*nf) ? exp_bit(ev[(c-1)/12], (c-1)%12) : 1'b1;
        eb = (c <= 12*nf);
        ed = (c > 1) && ((c-1) % 12 == 0) && (c <= 12*nf + 1);
        chk($sformatf("seq%0d_tx_c%0d", mode, c), tx, et);
        chk($sformatf("seq%0d_busy_c%0d", mode, c), tx_busy, eb);
        chk($sformatf("seq%0d_done_c%0d", mode, c), tx_done, ed);
      end
      if (mode == 1 && c == 2) chk("seq1_count_c2", fifo_count, 2);
      if (mode == 2 && c == 4) chk("seq2_ready_full", tx_ready, 0);
      if (mode == 2 && c == 5) chk("seq2_count_full", fifo_count, 4);
    end
    tx_valid = 0;
    if (mode == 1) chk("seq1_peak", peak, 2);
    if (mode == 2) chk("seq2_peak", peak, 4);
    chk($sformatf("seq%0d_empty_end", mode), fifo_count, 0);
  endtask

  initial begin
    // ID 5 = 0000_0101, BIT_TICKS=1: push, then 12 frame clocks, then idle with done.
    tbl[0]  = '{1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1};
    tbl[1]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[2]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[3]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[4]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[5]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[6]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[7]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[8]  = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[9]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[10] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[11] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[12] = '{1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[13] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1};
    tbl[14] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1};

    do_reset();
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_tx4", tx4, 1);

    for (int i = 0; i < 15; i++) begin
      tx_valid = tbl[i].vld;
      tx_data  = tbl[i].data;
      step();
      chk($sformatf("vec%0d_tx", i), tx, tbl[i].tx);
      chk($sformatf("vec%0d_busy", i), tx_busy, tbl[i].busy);
      chk($sformatf("vec%0d_done", i), tx_done, tbl[i].done);
      chk($sformatf("vec%0d_count", i), fifo_count, tbl[i].cnt);
      chk($sformatf("vec%0d_ready", i), tx_ready, tbl[i].rdy);
    end
    tx_valid = 0;

    // Back-to-back frames 13, 35, 44.
    do_reset();
    pv = '{8'd13, 8'd35, 8'd44, 8'd0, 8'd0, 8'd0};
    ev = '{8'd13, 8'd35, 8'd44, 8'd0, 8'd0, 8'd0};
    run_seq(3, 3, 1);

    // Overflow: six pushes, 46 dropped while full.
    do_reset();
    pv = '{8'd0, 8'd5, 8'd13, 8'd35, 8'd44, 8'd46};
    ev = '{8'd0, 8'd5, 8'd13, 8'd35, 8'd44, 8'd0};
    run_seq(6, 5, 2);

    // Reset during data bit b3 of ID 47 (0010_1111) with ID 13 queued.
    do_reset();
    tx_valid = 1; tx_data = 8'd47; step();
    tx_data = 8'd13; step();
    tx_valid = 0;
    for (int c = 2; c <= 7; c++) step();
    chk("mid_b3_tx", tx, 1);
    chk("mid_busy", tx_busy, 1);
    chk("mid_count", fifo_count, 1);
    #2 nRESET = 0;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_busy", tx_busy, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_ready", tx_ready, 1);
    step(); step(); step();
    nRESET = 1;
    for (int c = 0; c < 20; c++) begin
      step();
      chk($sformatf("post_rst_tx_c%0d", c), tx, 1);
      chk($sformatf("post_rst_busy_c%0d", c), tx_busy, 0);
    end

    // BIT_TICKS=4, ID 46 = 0010_1110: 48-clock frame.
    do_reset();
    tx_valid4 = 1; tx_data4 = 8'd46; step();
    tx_valid4 = 0;
    for (int c = 1; c <= 52; c++) begin
      step();
      chk($sformatf("bt4_tx_c%0d", c), tx4, (c <= 48) ? exp_bit(8'd46, (c-1)/4) : 1'b1);
      chk($sformatf("bt4_busy_c%0d", c), tx_busy4, (c <= 48));
      chk($sformatf("bt4_done_c%0d", c), tx_done4, (c == 49));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
